mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS core, directly downstream of execute.
- Holds the M pipeline register that execute fills with its result record: ALU result/address, store data, read/write flags, destination register and PC.
- Issues word loads/stores on the data bus through a valid/addr_ok/data_ok handshake, stalls upstream while a transaction is outstanding, and hands a completed record to writeback. Also exports forwarding information for the decode-stage bypass.

Parameters:
- ADDR_W, 32, address/PC width
- DATA_W, 32, data width (strobe width is DATA_W/8)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  execute presents a record
- in_ready  out  1  stage accepts a record this cycle
- in_pc  in  32  instruction PC
- in_regw  in  5  destination register; 0 = no write
- in_res  in  32  ALU result, or effective address when in_rm/in_wm is set
- in_sdata  in  32  store data
- in_rm  in  1  load word
- in_wm  in  1  store word
- dreq_valid  out  1  data-bus request valid
- dreq_addr  out  32  word address, low 2 bits forced 0
- dreq_strobe  out  4  byte enables: 4'hF for store, 4'h0 for load
- dreq_data  out  32  store data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  data/ack returned
- dresp_data  in  32  load data
- out_valid  out  1  record for writeback
- out_ready  in  1  writeback accepts
- out_pc  out  32  PC of record
- out_regw  out  5  destination; forced 0 for stores
- out_wdata  out  32  ALU result or load data
- fwd_regw  out  5  register held in stage; 0 when EMPTY
- fwd_data  out  32  value for bypass
- fwd_busy  out  1  record is a load whose data has not returned; decode must stall on a match

Behaviour:
- States: EMPTY, REQ, WAIT, DONE.
- Reset (async, any state, mid-transaction included): state = EMPTY and internal register cleared. All outputs read 0: dreq_valid, out_valid, fwd_regw, fwd_busy, out_*, dreq_*.
- in_ready = (state==EMPTY) | (state==DONE & out_ready). A record is accepted when in_valid & in_ready.
- Accepting a record:
  - in_rm=in_wm=0: go to DONE with out_wdata=in_res.
  - Otherwise go to REQ, latching address, sdata, rm/wm, regw and PC.
  - in_rm and in_wm both set: treat as load.
- REQ:
  - dreq_valid=1. addr, strobe and data stay stable until addr_ok.
  - addr_ok without data_ok: go to WAIT.
  - addr_ok and data_ok in the same cycle: go to DONE.
- WAIT:
  - dreq_valid=0.
  - On data_ok, go to DONE; a load captures dresp_data into out_wdata.
- DONE:
  - out_valid=1.
  - If out_ready: with a new record accepted the same cycle, transition per the accept rules (back-to-back, no bubble); otherwise go to EMPTY.
  - If not out_ready: hold all outputs stable.
- dresp_* are ignored in EMPTY and DONE. This covers stray responses arriving after a reset.
- Latency from accept:
  - ALU op: out_valid in the next cycle.
  - Memory op with addr_ok and data_ok both in the first REQ cycle: out_valid 2 cycles after accept.
  - Each extra wait cycle on the bus adds 1.
- Throughput: 1 ALU record per cycle while out_ready=1.
- Stores: out_regw=0, out_wdata=0.
- Forwarding:
  - fwd_regw = latched regw (0 for stores, 0 when EMPTY).
  - fwd_data = out_wdata.
  - fwd_busy = load & state in {REQ, WAIT}.
- At most one bus transaction outstanding; no new request issues before data_ok.

Test Plan:
- Reset, then addu record in_res=0x0000_0007, regw=3, pc=0xBFC0_0000 -> next cycle out_valid=1, out_regw=3, out_wdata=7, no dreq_valid.
- lw addr=0x8000_0010 regw=5; addr_ok after 2 cycles, data_ok 3 cycles later with 0xDEAD_BEEF -> dreq_valid stable with addr 0x8000_0010 and strobe 0 until addr_ok; fwd_busy=1 throughout; out_wdata=0xDEAD_BEEF; in_ready=0 until DONE.
- sw addr=0x8000_0020 data=0x1234_5678, addr_ok and data_ok same first cycle -> single request with strobe F and data 0x1234_5678; DONE 2 cycles after accept; out_regw=0.
- 4 back-to-back ALU records with out_ready=1 -> one out_valid per cycle, in order. out_ready held 0 for 3 cycles -> outputs frozen, in_ready=0.
- Reset asserted in WAIT, data_ok arrives the cycle after reset releases -> state EMPTY, out_valid stays 0, response ignored.
- Record with in_res=0x8000_0013 load -> dreq_addr=0x8000_0010.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage: M pipeline register, data-bus handshake, writeback hand-off, bypass info
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_pc,
    input  logic [4:0]          in_regw,
    input  logic [DATA_W-1:0]   in_res,
    input  logic [DATA_W-1:0]   in_sdata,
    input  logic                in_rm,
    input  logic                in_wm,
    output logic                dreq_valid,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic [DATA_W/8-1:0] dreq_strobe,
    output logic [DATA_W-1:0]   dreq_data,
    input  logic                dresp_addr_ok,
    input  logic                dresp_data_ok,
    input  logic [DATA_W-1:0]   dresp_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [4:0]          out_regw,
    output logic [DATA_W-1:0]   out_wdata,
    output logic [4:0]          fwd_regw,
    output logic [DATA_W-1:0]   fwd_data,
    output logic                fwd_busy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   sdata_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [4:0]          regw_q;
    logic                load_q;
    logic                store_q;
    logic                accept;

    assign in_ready = (state == EMPTY) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= EMPTY;
            pc_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            wdata_q <= '0;
            regw_q  <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
        end else if (accept) begin
            pc_q    <= in_pc;
            addr_q  <= {in_res[ADDR_W-1:2], 2'b00};
            sdata_q <= in_sdata;
            // rm and wm both set behaves as a plain load
            load_q  <= in_rm;
            store_q <= in_wm && !in_rm;
            if (in_rm || in_wm) begin
                state   <= REQ;
                regw_q  <= in_rm ? in_regw : 5'd0;
                wdata_q <= '0;
            end else begin
                state   <= DONE;
                regw_q  <= in_regw;
                wdata_q <= in_res;
            end
        end else begin
            case (state)
                REQ: begin
                    if (dresp_addr_ok) begin
                        if (dresp_data_ok) begin
                            state <= DONE;
                            if (load_q) wdata_q <= dresp_data;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dresp_data_ok) begin
                        state <= DONE;
                        if (load_q) wdata_q <= dresp_data;
                    end
                end
                DONE: begin
                    if (out_ready) state <= EMPTY;
                end
                default: ;
            endcase
        end
    end

    // Bus outputs are only driven in REQ so stale request data never leaks onto the bus
    assign dreq_valid  = (state == REQ);
    assign dreq_addr   = (state == REQ) ? addr_q : '0;
    assign dreq_strobe = (state == REQ && store_q) ? '1 : '0;
    assign dreq_data   = (state == REQ) ? sdata_q : '0;

    assign out_valid = (state == DONE);
    assign out_pc    = pc_q;
    assign out_regw  = regw_q;
    assign out_wdata = wdata_q;

    assign fwd_regw = (state == EMPTY) ? 5'd0 : regw_q;
    assign fwd_data = wdata_q;
    assign fwd_busy = load_q && (state == REQ || state == WAIT);

endmodule
